// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Pong game sequencer between the keyboard decoder, the ball motion block
//   and the score/VGA overlay. Runs the game state machine, generates the
//   per-frame ball move strobe, keeps both scores, picks the serve direction
//   and declares the winner.
//
//   Optional feature: define PONG_PAUSE_EN to enable the PAUSED state
//   (PAUSE_KEY toggles PLAY <-> PAUSED). Without it encoding 5 is illegal.
//
// Ports
//   i_CLK        system clock
//   i_RST_n      asynchronous active-low reset
//   i_key_valid  one-cycle strobe, i_key_byte holds a new keypress
//   i_key_byte   ASCII key code
//   i_p1_scored  level, ball passed the right bound (point for P1)
//   i_p2_scored  level, ball passed the left bound (point for P2)
//   o_move_tick  one-cycle ball move-enable strobe
//   o_ball_hold  1 = ball forced to centre and not moved
//   o_serve_dir  initial ball X direction, 0 = right, 1 = left
//   o_p1_score   player 1 score
//   o_p2_score   player 2 score
//   o_state      current state encoding for the overlay
//   o_winner     0 = none, 1 = P1, 2 = P2
module pong_game_ctrl #(
   parameter logic [7:0]  START_KEY    = 8'd103,
   parameter logic [7:0]  RESTART_KEY  = 8'd98,
   parameter logic [7:0]  PAUSE_KEY    = 8'd112,
   parameter int unsigned FRAME_DIV    = 416667,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 7
) (
   input  logic       i_CLK,
   input  logic       i_RST_n,
   input  logic       i_key_valid,
   input  logic [7:0] i_key_byte,
   input  logic       i_p1_scored,
   input  logic       i_p2_scored,
   output logic       o_move_tick,
   output logic       o_ball_hold,
   output logic       o_serve_dir,
   output logic [3:0] o_p1_score,
   output logic [3:0] o_p2_score,
   output logic [2:0] o_state,
   output logic [1:0] o_winner
);

   localparam int unsigned          FRAME_W    = $clog2(FRAME_DIV);
   localparam int unsigned          SERVE_W    = $clog2(SERVE_FRAMES + 1);
   localparam logic [FRAME_W-1:0]   FRAME_LAST = FRAME_W'(FRAME_DIV - 1);
   localparam logic [SERVE_W-1:0]   SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
   localparam logic [3:0]           WIN_VAL    = 4'(WIN_SCORE);

   // Elaboration-time sanity check of the parameter set (keys must be distinct)
   if (FRAME_DIV < 2 || SERVE_FRAMES < 1 || WIN_SCORE < 1 || WIN_SCORE > 15 ||
       START_KEY == RESTART_KEY || PAUSE_KEY == START_KEY ||
       PAUSE_KEY == RESTART_KEY) begin : g_bad_cfg
      $error("pong_game_ctrl: illegal parameter set");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_POINT     = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_PAUSED    = 3'd5
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [FRAME_W-1:0]   frame_cnt;
   logic [SERVE_W-1:0]   serve_cnt;
   logic [SERVE_W-1:0]   serve_cnt_nxt;
   logic [3:0]           p1_score;
   logic [3:0]           p1_score_nxt;
   logic [3:0]           p2_score;
   logic [3:0]           p2_score_nxt;
   logic                 serve_dir;
   logic                 serve_dir_nxt;
   logic [1:0]           winner;
   logic [1:0]           winner_nxt;
   logic                 ball_hold;
   logic                 ball_hold_nxt;
   logic                 move_tick;
   logic                 p1_q;
   logic                 p2_q;

   logic                 frame_tick_c;
   logic                 p1_edge_c;
   logic                 p2_edge_c;
   logic                 key_start_c;
   logic                 key_restart_c;
`ifdef PONG_PAUSE_EN
   logic                 key_pause_c;
`endif

   // Key decode and scored-edge detection
   always_comb begin
      frame_tick_c  = (frame_cnt == FRAME_LAST);
      p1_edge_c     = i_p1_scored & ~p1_q;
      p2_edge_c     = i_p2_scored & ~p2_q;
      key_start_c   = i_key_valid && (i_key_byte == START_KEY);
      key_restart_c = i_key_valid && (i_key_byte == RESTART_KEY);
`ifdef PONG_PAUSE_EN
      key_pause_c   = i_key_valid && (i_key_byte == PAUSE_KEY);
`endif
   end

   // State register
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-value logic
   always_comb begin
      state_nxt     = state;
      serve_cnt_nxt = serve_cnt;
      p1_score_nxt  = p1_score;
      p2_score_nxt  = p2_score;
      serve_dir_nxt = serve_dir;
      winner_nxt    = winner;
      ball_hold_nxt = 1'b1;

      if (key_restart_c) begin
         // Restart outranks every other event in the same cycle
         state_nxt     = ST_IDLE;
         serve_cnt_nxt = '0;
         p1_score_nxt  = '0;
         p2_score_nxt  = '0;
         winner_nxt    = 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_start_c) begin
                  state_nxt     = ST_SERVE;
                  serve_cnt_nxt = '0;
                  p1_score_nxt  = '0;
                  p2_score_nxt  = '0;
                  serve_dir_nxt = 1'b0;
               end
            end

            ST_SERVE: begin
               if (frame_tick_c) begin
                  serve_cnt_nxt = serve_cnt + SERVE_W'(1);
                  if (serve_cnt == SERVE_LAST) begin
                     state_nxt = ST_PLAY;
                  end
               end
            end

            ST_PLAY: begin
`ifdef PONG_PAUSE_EN
               if (key_pause_c) begin
                  state_nxt = ST_PAUSED;
               end else
`endif
               if (p1_edge_c && p2_edge_c) begin
                  // Simultaneous exits: re-serve without scoring
                  state_nxt = ST_POINT;
               end else if (p1_edge_c) begin
                  state_nxt     = ST_POINT;
                  p1_score_nxt  = p1_score + 4'd1;
                  serve_dir_nxt = 1'b0;
               end else if (p2_edge_c) begin
                  state_nxt     = ST_POINT;
                  p2_score_nxt  = p2_score + 4'd1;
                  serve_dir_nxt = 1'b1;
               end
            end

            ST_POINT: begin
               if (p1_score == WIN_VAL) begin
                  state_nxt  = ST_GAME_OVER;
                  winner_nxt = 2'd1;
               end else if (p2_score == WIN_VAL) begin
                  state_nxt  = ST_GAME_OVER;
                  winner_nxt = 2'd2;
               end else begin
                  state_nxt     = ST_SERVE;
                  serve_cnt_nxt = '0;
               end
            end

            ST_GAME_OVER: begin
               state_nxt = ST_GAME_OVER;
            end

`ifdef PONG_PAUSE_EN
            ST_PAUSED: begin
               if (key_pause_c) begin
                  state_nxt = ST_PLAY;
               end
            end
`endif

            default: begin
               // Illegal encodings recover like a restart
               state_nxt     = ST_IDLE;
               serve_cnt_nxt = '0;
               p1_score_nxt  = '0;
               p2_score_nxt  = '0;
               winner_nxt    = 2'd0;
            end
         endcase
      end

      // Ball moves freely only in PLAY; in PAUSED it is frozen in place
      ball_hold_nxt = (state_nxt != ST_PLAY) && (state_nxt != ST_PAUSED);
   end

   // Datapath registers: frame divider, serve counter, scores, outputs
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         frame_cnt <= '0;
         serve_cnt <= '0;
         p1_score  <= '0;
         p2_score  <= '0;
         serve_dir <= 1'b0;
         winner    <= 2'd0;
         ball_hold <= 1'b1;
         move_tick <= 1'b0;
         p1_q      <= 1'b0;
         p2_q      <= 1'b0;
      end else begin
         frame_cnt <= frame_tick_c ? '0 : frame_cnt + FRAME_W'(1);
         serve_cnt <= serve_cnt_nxt;
         p1_score  <= p1_score_nxt;
         p2_score  <= p2_score_nxt;
         serve_dir <= serve_dir_nxt;
         winner    <= winner_nxt;
         ball_hold <= ball_hold_nxt;
         move_tick <= frame_tick_c && (state == ST_PLAY);
         p1_q      <= i_p1_scored;
         p2_q      <= i_p2_scored;
      end
   end

   assign o_move_tick = move_tick;
   assign o_ball_hold = ball_hold;
   assign o_serve_dir = serve_dir;
   assign o_p1_score  = p1_score;
   assign o_p2_score  = p2_score;
   assign o_state     = state;
   assign o_winner    = winner;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level Pong game sequencer sitting between the keyboard decoder, the ball motion block and the score/VGA overlay.
- Owns the game state machine, generates the per-frame ball move strobe, and holds the ball at centre during serve and idle phases.
- Keeps both player scores, selects the serve direction and declares the winner.

Parameters:
- START_KEY, 103, key byte ('g') that starts a game from IDLE.
- RESTART_KEY, 98, key byte ('b') that aborts to IDLE from any state and clears the scores.
- PAUSE_KEY, 112, key byte ('p') that toggles pause; only used with PONG_PAUSE_EN.
- FRAME_DIV, 416667, clock cycles per move strobe (60 Hz at 25 MHz); must be >= 2.
- SERVE_FRAMES, 60, number of frame ticks the ball is held in SERVE before play.
- WIN_SCORE, 7, score that ends the game; range 1..15.

Ports:
- i_CLK, in, 1, system clock.
- i_RST_n, in, 1, asynchronous active-low reset.
- i_key_valid, in, 1, one-cycle strobe: i_key_byte is a new keypress.
- i_key_byte, in, 8, ASCII key code; sampled only when i_key_valid=1.
- i_p1_scored, in, 1, level from the ball block: ball passed the right bound.
- i_p2_scored, in, 1, level from the ball block: ball passed the left bound.
- o_move_tick, out, 1, one-cycle ball move-enable strobe.
- o_ball_hold, out, 1, 1 = ball block forces the ball to centre and does not move it.
- o_serve_dir, out, 1, initial X direction of the ball: 0 = right, 1 = left.
- o_p1_score, out, 4, player 1 score.
- o_p2_score, out, 4, player 2 score.
- o_state, out, 3, current state encoding, used by the overlay.
- o_winner, out, 2, 0 = none, 1 = P1, 2 = P2; valid in GAME_OVER only.

Behaviour:
- Reset (asynchronous, i_RST_n=0):
  - state = IDLE; both scores = 0; o_serve_dir = 0; o_winner = 0; o_move_tick = 0; o_ball_hold = 1.
  - Frame counter = 0; serve counter = 0; scored edge registers = 0.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4, PAUSED=5.
- Frame counter:
  - Free-runs 0..FRAME_DIV-1 and wraps to 0.
  - Internal frame_tick = 1 in the cycle the counter equals FRAME_DIV-1.
  - o_move_tick is registered: it equals 1 on the cycle after a frame_tick, and only if the state was PLAY on the frame_tick cycle.
- Scored inputs:
  - Rising-edge detected against a registered copy of each input.
  - Edges are acted on only while in PLAY; edges arriving in any other state are discarded.
- o_ball_hold = 1 in IDLE, SERVE, POINT and GAME_OVER; 0 in PLAY and PAUSED.
- Transitions:
  - IDLE: START key -> SERVE. On this transition scores clear to 0 and o_serve_dir = 0.
  - SERVE: serve counter clears on entry and increments on each frame_tick. When it reaches SERVE_FRAMES -> PLAY.
  - PLAY, P1 edge only: o_p1_score += 1; o_serve_dir = 0 (serve toward P2, who conceded); -> POINT.
  - PLAY, P2 edge only: o_p2_score += 1; o_serve_dir = 1; -> POINT.
  - PLAY, both edges in the same cycle: no score change, o_serve_dir unchanged, -> POINT (re-serve).
  - POINT lasts exactly 1 cycle:
    - o_p1_score == WIN_SCORE -> GAME_OVER, o_winner = 1.
    - else o_p2_score == WIN_SCORE -> GAME_OVER, o_winner = 2.
    - else -> SERVE.
  - GAME_OVER: holds until a RESTART key; the START key is ignored.
  - RESTART key in any state (IDLE included): -> IDLE next cycle; scores = 0; o_winner = 0; serve counter = 0. RESTART has priority over every other event in the same cycle.
- Keys:
  - Keys other than START, RESTART and (when enabled) PAUSE are ignored.
  - A START key outside IDLE is ignored.
- Scores:
  - 4-bit unsigned.
  - Cannot exceed WIN_SCORE, because play stops at WIN_SCORE.
- Illegal state encodings (6, 7): -> IDLE on the next cycle, with the same clears as RESTART.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- Defined:
  - PAUSE_KEY in PLAY -> PAUSED. PAUSE_KEY in PAUSED -> PLAY.
  - In PAUSED: o_move_tick = 0, scored edges are discarded, o_ball_hold = 0 (ball frozen in place), and the serve counter and scores are frozen.
  - RESTART from PAUSED -> IDLE.
- Not defined:
  - PAUSED is unreachable and PAUSE_KEY is ignored.
  - Encoding 5 is treated as illegal.

Test Plan:
- Reset then idle:
  - Stimulus: assert i_RST_n=0 mid-count, release, no keys for 3 frames.
  - Response: o_state=0, o_ball_hold=1, scores 0, no o_move_tick pulses.
- Start and serve (FRAME_DIV=4, SERVE_FRAMES=3):
  - Stimulus: START key.
  - Response: SERVE next cycle; PLAY after the 3rd frame_tick; o_move_tick then pulses every 4 cycles, 1 cycle wide.
- Point and serve direction:
  - Stimulus: in PLAY, raise i_p2_scored and hold it high 10 cycles.
  - Response: o_p2_score=1 (incremented once only), o_serve_dir=1, POINT for 1 cycle, then SERVE with o_ball_hold=1.
- Simultaneous score:
  - Stimulus: both scored inputs rise in the same cycle.
  - Response: scores unchanged, o_serve_dir unchanged, PLAY -> POINT -> SERVE.
- Win (WIN_SCORE=2):
  - Stimulus: two P1 points.
  - Response: GAME_OVER, o_winner=1, o_p1_score=2; a START key is ignored; RESTART gives o_state=0, scores 0, o_winner=0.
- Pause (PONG_PAUSE_EN defined):
  - Stimulus: PAUSE_KEY in PLAY, then a P1 edge, then PAUSE_KEY again.
  - Response: no o_move_tick and no score change while PAUSED; ticks resume after the second PAUSE_KEY.
